acc_dump: RTL
=============

# acc_dump

Integrate-and-dump stage that sits directly downstream of the tracking front end. It samples the free-running 16-bit channel accumulator at every C/A code epoch, which is a wrap of the code phase to 0. It converts consecutive samples into signed per-epoch correlation sums and adds `DUMP_EPOCHS` of them together. It then presents the result to the loop/processor side over a valid/ready handshake.

## Interface
- `ACC_WIDTH`, 16, width of the upstream accumulator (two's complement, wraps freely).
- `OUT_WIDTH`, 21, width of the dumped signed sum; must satisfy `OUT_WIDTH >= ACC_WIDTH + ceil(log2(DUMP_EPOCHS))`.
- `DUMP_EPOCHS`, 1, number of code epochs per dump, 1..20.
- `clk`  in  1  sample clock, the same 16.8 MHz clock as the tracking channel; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `enable`  in  1  channel enable; low forces the PRIME state (see Operation).
- `codeShift`  in  10  current C/A code phase from the code generator.
- `accumulator`  in  ACC_WIDTH  running accumulator from the tracking channel.
- `out_value`  out  OUT_WIDTH  signed dumped correlation sum.
- `out_valid`  out  1  `out_value` holds an unconsumed dump.
- `out_ready`  in  1  consumer accepts `out_value` when high together with `out_valid`.
- `overrun`  out  1  sticky; a dump was lost because the output was still occupied.

## Operation
- Epoch detect:
  - Register `codeShift` into `cs_q` each cycle.
  - `epoch` is true when `codeShift == 0` and `cs_q != 0`.
  - Exactly one epoch fires per code wrap, regardless of how many clocks phase 0 persists.
  - `cs_q` resets to 0, so a phase already at 0 out of reset does not produce an epoch.
- Delta:
  - `delta = accumulator - snap`, computed modulo 2^ACC_WIDTH and interpreted as signed.
  - `delta` is sign-extended to OUT_WIDTH.
  - `snap` is the accumulator value captured at the previous epoch.
- State machine:
  - PRIME:
    - On `epoch`: `snap <= accumulator`, `sum <= 0`, `cnt <= 0`, go to ACCUM.
    - No dump is produced in PRIME.
  - ACCUM:
    - On `epoch`: `snap <= accumulator`.
    - If `cnt == DUMP_EPOCHS-1`: dump `sum + delta`, then `sum <= 0` and `cnt <= 0`.
    - Otherwise: `sum <= sum + delta` and `cnt <= cnt + 1`.
  - `enable` low: next state is PRIME and `sum`/`cnt` are cleared. The `out_*` registers and `overrun` are untouched.
- Output register:
  - A dump loads `out_value` and sets `out_valid` if `out_valid == 0`, or if `out_ready == 1` in the same cycle.
  - Otherwise the new dump is discarded: `out_value` is held and `overrun <= 1`.
  - A handshake (`out_valid & out_ready`) with no simultaneous dump clears `out_valid`.
  - `out_value` is held stable while `out_valid` is high and unacknowledged.
- Arithmetic:
  - `sum` is OUT_WIDTH signed and does not saturate.
  - The parameter rule above guarantees no overflow, since the per-epoch delta magnitude is below 2^(ACC_WIDTH-1).

## Timing
- Reset: `out_value = 0`, `out_valid = 0`, `overrun = 0`, state PRIME, `sum = 0`, `cnt = 0`, `snap = 0`, `cs_q = 0`.
- A reset mid-operation discards any partial sum and pending dump.
- `accumulator` changes on the falling edge upstream, so it is stable at the rising edge and is sampled directly, with no extra sync stage.
- Latency: the dump is visible on `out_value`/`out_valid` one clock after the rising edge where the final `epoch` is true.
- First dump after reset or after `enable` rises: DUMP_EPOCHS+1 epochs. The first epoch only primes.
- `enable` low on the same edge as an `epoch`: `enable` wins. No dump occurs and the state goes to PRIME.
- Dump and handshake on the same edge: the new value loads, `out_valid` stays 1, and `overrun` is not set.

## Test plan
- Priming and single-epoch dump:
  - Stimulus: DUMP_EPOCHS=1; epochs with accumulator 100, then 350, then 300.
  - Required response: the first epoch gives no dump. Then `out_value` is 250, then -50, each with `out_valid` one clock after its epoch; `out_ready` is held 1.
- Wrap-around:
  - Stimulus: accumulator 0x7FF0 at the priming epoch, then 0x8010 at the next epoch.
  - Required response: `out_value = +32`.
  - Stimulus: accumulator 0xFFF0, then 0x0005.
  - Required response: `out_value = +21`.
- Multi-epoch:
  - Stimulus: DUMP_EPOCHS=4; deltas +10, -3, +7, +100.
  - Required response: exactly one dump, `out_value = 114`, one clock after the 4th delta epoch.
- Backpressure:
  - Stimulus: `out_ready` = 0 across two dumps (+5, then +9).
  - Required response: `out_value` stays 5, `overrun` = 1 and sticky; raising `out_ready` clears `out_valid`.
  - Stimulus: dump coincident with a handshake.
  - Required response: the new value loads, with no overrun.
- Held phase 0 / enable drop:
  - Stimulus: `codeShift` held at 0 for 20 clocks.
  - Required response: a single epoch.
  - Stimulus: `enable` dropped mid-accumulation, then restored.
  - Required response: the partial sum is discarded, and the next dump requires DUMP_EPOCHS+1 epochs.
- Reset mid-operation:
  - Stimulus: `reset` = 0 for 1 clock while `out_valid` = 1 and `cnt` = 2.
  - Required response: all outputs 0 on the next edge, and the state returns to PRIME.

Source files
------------

// File: rtl/acc_dump.sv
// Integrate-and-dump stage: samples the free-running channel accumulator at each
// C/A code epoch, sums DUMP_EPOCHS per-epoch deltas and offers the result on a valid/ready port.
module acc_dump #(
  parameter int ACC_WIDTH   = 16,
  parameter int OUT_WIDTH   = 21,
  parameter int DUMP_EPOCHS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [9:0]           codeShift,
  input  logic [ACC_WIDTH-1:0] accumulator,
  output logic [OUT_WIDTH-1:0] out_value,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 overrun
);

  localparam int CNT_W = (DUMP_EPOCHS > 1) ? $clog2(DUMP_EPOCHS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DUMP_EPOCHS - 1);

  typedef enum logic [0:0] {
    ST_PRIME = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [9:0]           cs_q_r;
  logic [ACC_WIDTH-1:0] snap_r;
  logic [ACC_WIDTH-1:0] snap_nxt_s;
  logic [OUT_WIDTH-1:0] sum_r;
  logic [OUT_WIDTH-1:0] sum_nxt_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [CNT_W-1:0]     cnt_nxt_s;
  logic [OUT_WIDTH-1:0] out_value_r;
  logic                 out_valid_r;
  logic                 overrun_r;

  logic                 epoch_s;
  logic [ACC_WIDTH-1:0] delta_s;
  logic [OUT_WIDTH-1:0] delta_ext_s;
  logic [OUT_WIDTH-1:0] sum_plus_s;
  logic                 dump_s;
  logic                 load_s;
  logic                 ack_s;

  // The delta wraps modulo 2^ACC_WIDTH, so a plain subtract handles accumulator roll-over.
  assign epoch_s     = (codeShift == 10'd0) && (cs_q_r != 10'd0);
  assign delta_s     = accumulator - snap_r;
  assign delta_ext_s = {{(OUT_WIDTH - ACC_WIDTH){delta_s[ACC_WIDTH-1]}}, delta_s};
  assign sum_plus_s  = sum_r + delta_ext_s;
  assign load_s      = dump_s & (~out_valid_r | out_ready);
  assign ack_s       = out_valid_r & out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_PRIME;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a dropped enable always returns to PRIME
  always_comb begin
    state_nxt_s = state_r;
    if (!enable) begin
      state_nxt_s = ST_PRIME;
    end else begin
      case (state_r)
        ST_PRIME: begin
          if (epoch_s) begin
            state_nxt_s = ST_ACCUM;
          end else begin
            state_nxt_s = ST_PRIME;
          end
        end
        ST_ACCUM: state_nxt_s = ST_ACCUM;
        default:  state_nxt_s = ST_PRIME;
      endcase
    end
  end

  // Per-state datapath decisions: snapshot, running sum, epoch count and dump strobe
  always_comb begin
    dump_s     = 1'b0;
    snap_nxt_s = snap_r;
    sum_nxt_s  = sum_r;
    cnt_nxt_s  = cnt_r;
    if (!enable) begin
      sum_nxt_s = {OUT_WIDTH{1'b0}};
      cnt_nxt_s = {CNT_W{1'b0}};
    end else if (epoch_s) begin
      snap_nxt_s = accumulator;
      case (state_r)
        ST_PRIME: begin
          sum_nxt_s = {OUT_WIDTH{1'b0}};
          cnt_nxt_s = {CNT_W{1'b0}};
        end
        ST_ACCUM: begin
          if (cnt_r == CNT_LAST) begin
            dump_s    = 1'b1;
            sum_nxt_s = {OUT_WIDTH{1'b0}};
            cnt_nxt_s = {CNT_W{1'b0}};
          end else begin
            sum_nxt_s = sum_plus_s;
            cnt_nxt_s = cnt_r + CNT_W'(1);
          end
        end
        default: begin
          sum_nxt_s = {OUT_WIDTH{1'b0}};
          cnt_nxt_s = {CNT_W{1'b0}};
        end
      endcase
    end else begin
      snap_nxt_s = snap_r;
    end
  end

  // Epoch detector and accumulation registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      cs_q_r <= 10'd0;
      snap_r <= {ACC_WIDTH{1'b0}};
      sum_r  <= {OUT_WIDTH{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
    end else begin
      cs_q_r <= codeShift;
      snap_r <= snap_nxt_s;
      sum_r  <= sum_nxt_s;
      cnt_r  <= cnt_nxt_s;
    end
  end

  // Output holding register; a dump into an occupied, unacknowledged slot is lost
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_value_r <= {OUT_WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      if (load_s) begin
        out_value_r <= sum_plus_s;
        out_valid_r <= 1'b1;
      end else if (ack_s) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
      overrun_r <= overrun_r | (dump_s & ~load_s);
    end
  end

  assign out_value = out_value_r;
  assign out_valid = out_valid_r;
  assign overrun   = overrun_r;

endmodule
